// File: rtl/audio_seq_pkg.sv
// Shared types and helpers for the audio sample sequencer: FSM states,
// filter-type constants, midscale and saturating counter helpers.
package audio_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE
  } seq_state_t;

  localparam logic LPF = 1'b0;
  localparam logic HPF = 1'b1;

  function automatic logic [31:0] midscale(input int unsigned n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Circular output buffer between the filter capture and the PWM duty register.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module sample_fifo #(
  parameter int N          = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [N-1:0]                  din,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [N-1:0]                  head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [N-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_reg == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign level   = level_reg;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_sequencer.sv
// Steps one ADC sample at a time through the external IIR filter and buffers results for the PWM.
// Optional statistics counters are built only when AUDIO_SEQ_STATS_EN is defined.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int N          = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE     = 2,
  parameter int F_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N-1:0]                  adc_data,
  input  logic                          adc_valid,
  input  logic                          pwm_ready,
  input  logic [F_W-1:0]                cfg_f,
  input  logic                          cfg_hpf,
  input  logic                          cfg_wr,
  input  logic                          clr_status,
  output logic [N-1:0]                  x_cur,
  output logic [N-1:0]                  x_prev,
  output logic [N-1:0]                  y_prev,
  output logic [F_W-1:0]                filt_f,
  output logic                          filt_hpf,
  input  logic [N-1:0]                  filt_out,
  output logic [N-1:0]                  pwm_duty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overrun,
  output logic                          underrun,
  output logic [15:0]                   sample_cnt,
  output logic [15:0]                   overrun_cnt,
  output logic [15:0]                   underrun_cnt
);

  localparam int          CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [31:0] MID_WORD = midscale(N);
  localparam logic [N-1:0] MID     = MID_WORD[N-1:0];

  // Enum literals are package-qualified: the SETTLE parameter shadows the state name.
  seq_state_t     state_reg;
  logic [CW-1:0]  settle_cnt_reg;
  logic [N-1:0]   hold_reg;
  logic [N-1:0]   x_cur_reg, x_prev_reg, y_prev_reg, pwm_duty_reg;
  logic [F_W-1:0] filt_f_reg, pend_f_reg;
  logic           filt_hpf_reg, pend_hpf_reg, pend_valid_reg;
  logic           busy_reg, overrun_reg, underrun_reg;

  logic [1:0] async_in;
  logic [1:0] evt;
  logic       sample_evt, pop_evt;
  logic       push, fifo_full, fifo_empty, fifo_drop, busy_drop, underrun_set;
  logic [N-1:0] fifo_head;

  assign async_in = {pwm_ready, adc_valid};

  // Two synchroniser flops, one history flop, and a registered rising-edge pulse.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic [2:0] sync_reg;
    logic       evt_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_reg <= '0;
        evt_reg  <= 1'b0;
      end else begin
        sync_reg <= {sync_reg[1:0], async_in[gi]};
        evt_reg  <= sync_reg[1] & ~sync_reg[2];
      end
    end
    assign evt[gi] = evt_reg;
  end

  assign sample_evt   = evt[0];
  assign pop_evt      = evt[1];
  assign push         = (state_reg == audio_seq_pkg::CAPTURE);
  assign fifo_drop    = push & fifo_full & ~pop_evt;
  assign busy_drop    = sample_evt & (state_reg != audio_seq_pkg::IDLE);
  assign underrun_set = pop_evt & fifo_empty;

  sample_fifo #(
    .N          (N),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_evt),
    .din   (filt_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= audio_seq_pkg::IDLE;
      settle_cnt_reg <= '0;
      busy_reg       <= 1'b0;
      hold_reg       <= MID;
      x_cur_reg      <= MID;
      x_prev_reg     <= MID;
      y_prev_reg     <= MID;
      filt_f_reg     <= '0;
      filt_hpf_reg   <= LPF;
    end else begin
      case (state_reg)
        audio_seq_pkg::IDLE: begin
          if (sample_evt) begin
            hold_reg  <= adc_data;
            busy_reg  <= 1'b1;
            state_reg <= audio_seq_pkg::LOAD;
          end
        end
        audio_seq_pkg::LOAD: begin
          x_prev_reg <= x_cur_reg;
          x_cur_reg  <= hold_reg;
          if (pend_valid_reg) begin
            filt_f_reg   <= pend_f_reg;
            filt_hpf_reg <= pend_hpf_reg;
            // Switching filter type restarts history so the new filter does not ring on stale state.
            if (pend_hpf_reg != filt_hpf_reg) begin
              x_prev_reg <= hold_reg;
              y_prev_reg <= MID;
            end
          end
          settle_cnt_reg <= '0;
          state_reg      <= audio_seq_pkg::SETTLE;
        end
        audio_seq_pkg::SETTLE: begin
          if (settle_cnt_reg == CW'(SETTLE - 1)) begin
            state_reg <= audio_seq_pkg::CAPTURE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + CW'(1);
          end
        end
        audio_seq_pkg::CAPTURE: begin
          y_prev_reg <= filt_out;
          busy_reg   <= 1'b0;
          state_reg  <= audio_seq_pkg::IDLE;
        end
        default: state_reg <= audio_seq_pkg::IDLE;
      endcase
    end
  end

  // A write during LOAD lands after LOAD has consumed the old pending value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_reg <= 1'b0;
      pend_f_reg     <= '0;
      pend_hpf_reg   <= LPF;
    end else if (cfg_wr) begin
      pend_valid_reg <= 1'b1;
      pend_f_reg     <= cfg_f;
      pend_hpf_reg   <= cfg_hpf;
    end else if (state_reg == audio_seq_pkg::LOAD) begin
      pend_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_duty_reg <= MID;
      overrun_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (pop_evt && !fifo_empty) pwm_duty_reg <= fifo_head;
      overrun_reg  <= busy_drop | fifo_drop | (overrun_reg & ~clr_status);
      underrun_reg <= underrun_set | (underrun_reg & ~clr_status);
    end
  end

`ifdef AUDIO_SEQ_STATS_EN
  logic [15:0] sample_cnt_reg, overrun_cnt_reg, underrun_cnt_reg;
  logic [1:0]  drop_inc;

  assign drop_inc = {1'b0, busy_drop} + {1'b0, fifo_drop};

  always_ff @(posedge clk) begin
    if (reset || clr_status) begin
      sample_cnt_reg   <= '0;
      overrun_cnt_reg  <= '0;
      underrun_cnt_reg <= '0;
    end else begin
      sample_cnt_reg   <= sat_add16(sample_cnt_reg, {1'b0, push});
      overrun_cnt_reg  <= sat_add16(overrun_cnt_reg, drop_inc);
      underrun_cnt_reg <= sat_add16(underrun_cnt_reg, {1'b0, underrun_set});
    end
  end

  assign sample_cnt   = sample_cnt_reg;
  assign overrun_cnt  = overrun_cnt_reg;
  assign underrun_cnt = underrun_cnt_reg;
`else
  assign sample_cnt   = '0;
  assign overrun_cnt  = '0;
  assign underrun_cnt = '0;
`endif

  assign x_cur    = x_cur_reg;
  assign x_prev   = x_prev_reg;
  assign y_prev   = y_prev_reg;
  assign filt_f   = filt_f_reg;
  assign filt_hpf = filt_hpf_reg;
  assign pwm_duty = pwm_duty_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;
  assign underrun = underrun_reg;

endmodule
